// File: rtl/calc_pkg.sv
// Shared calculator types, seven-segment constants and the hex digit decoder.
package calc_pkg;

  typedef enum logic [2:0] {
    S0_IDLE      = 3'd0,
    S1_OPERAND1  = 3'd1,
    S2_OPCODE    = 3'd2,
    S3_OPERAND2  = 3'd3,
    S4_DISPLAY   = 3'd4,
    S5_CALCULATE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } opcode_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one load edge, then one bit per clock for 10 clocks.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [9:0]  bin_sr;
  logic [11:0] bcd_sr, corr;
  logic [21:0] nxt;
  logic [3:0]  cnt;

  always_comb begin
    corr = bcd_sr;
    for (int i = 0; i < 3; i++)
      if (bcd_sr[i*4 +: 4] >= 4'd5) corr[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    nxt = {corr, bin_sr} << 1;
  end

  // A new start always wins, so a changed input restarts mid-conversion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      bcd    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr <= bin;
        bcd_sr <= '0;
        cnt    <= 4'd10;
      end else if (cnt != 4'd0) begin
        bcd_sr <= nxt[21:10];
        bin_sr <= nxt[9:0];
        cnt    <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          done <= 1'b1;
          bcd  <= nxt[21:10];
        end
      end
    end
  end
endmodule

// File: rtl/calc_result_display.sv
// Executes the selected operation on entry to S5 and scans the value onto a
// 4-digit multiplexed seven-segment display (signed decimal or hex).
module calc_result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [1:0]  opcode,
  input  logic [5:0]  operand1,
  input  logic [5:0]  operand2,
  input  logic [5:0]  display_result,
  input  logic        display_mode,
  output logic [11:0] result,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam logic [1:0] X_IDLE = 2'd0, X_EXEC = 2'd1, X_FINISH = 2'd2;
  localparam int CW = $clog2(REFRESH_DIV);

  function automatic logic [11:0] sx6(input logic [5:0] v);
    return {{6{v[5]}}, v};
  endfunction

  function automatic logic [5:0] abs6(input logic [5:0] v);
    return v[5] ? -v : v;
  endfunction

  state_t      cur_st, prev_st;
  opcode_t     op_q;
  logic [1:0]  xst;
  logic [11:0] a_q, b_q, res_q, acc, acc_next, mcand;
  logic [5:0]  mb;
  logic [2:0]  step;
  logic        neg_q, result_valid, start;

  assign cur_st   = state_t'(state);
  assign start    = (cur_st == S5_CALCULATE) && (prev_st != S5_CALCULATE);
  assign busy     = (xst == X_EXEC);
  assign acc_next = acc + (mb[0] ? mcand : 12'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_st <= S0_IDLE;
      xst <= X_IDLE;
      op_q <= OP_ADD;
      {a_q, b_q, res_q, acc, mcand, result} <= '0;
      {mb, step, neg_q, done, result_valid} <= '0;
    end else begin
      prev_st <= cur_st;
      done    <= 1'b0;
      case (xst)
        X_IDLE: if (start) begin
          a_q   <= sx6(operand1);
          b_q   <= sx6(operand2);
          op_q  <= opcode_t'(opcode);
          neg_q <= operand1[5] ^ operand2[5];
          mcand <= {6'd0, abs6(operand1)};
          mb    <= abs6(operand2);
          acc   <= '0;
          step  <= 3'd5;
          xst   <= X_EXEC;
        end
        X_EXEC: begin
          if (cur_st != S5_CALCULATE) begin
            xst          <= X_IDLE;
            result_valid <= 1'b0;
          end else if (op_q != OP_MUL) begin
            case (op_q)
              OP_ADD:  res_q <= a_q + b_q;
              OP_SUB:  res_q <= a_q - b_q;
              default: res_q <= a_q & b_q;
            endcase
            xst <= X_FINISH;
          end else begin
            // Unsigned shift-add over the six multiplier bits, sign fixed at the end
            acc   <= acc_next;
            mcand <= mcand << 1;
            mb    <= mb >> 1;
            step  <= step - 3'd1;
            if (step == 3'd0) begin
              res_q <= neg_q ? -acc_next : acc_next;
              xst   <= X_FINISH;
            end
          end
        end
        X_FINISH: begin
          result       <= res_q;
          done         <= 1'b1;
          result_valid <= 1'b1;
          xst          <= X_IDLE;
        end
        default: xst <= X_IDLE;
      endcase
    end
  end

  logic [11:0]      sel_val, mag, bcd;
  logic [12:0]      key_q;
  logic             conv_start, bcd_done, pend_neg, pend_over, dec_neg, dec_over;
  logic [11:0]      dec_bcd;
  logic [3:0][6:0]  dig_seg;
  logic [CW-1:0]    ref_cnt;
  logic [1:0]       idx;

  always_comb begin
    if (cur_st == S5_CALCULATE && result_valid) sel_val = result;
    else if (cur_st == S0_IDLE)                 sel_val = '0;
    else                                        sel_val = sx6(display_result);
  end

  assign mag        = sel_val[11] ? -sel_val : sel_val;
  assign conv_start = ({display_mode, sel_val} != key_q);

  bin_to_bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (mag[9:0]),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Sign/overflow travel with the conversion so old digits stay coherent until done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '0;
      {pend_neg, pend_over, dec_neg, dec_over} <= '0;
      dec_bcd <= '0;
    end else begin
      key_q <= {display_mode, sel_val};
      if (conv_start) begin
        pend_neg  <= sel_val[11];
        pend_over <= (mag > 12'd999);
      end
      if (bcd_done) begin
        dec_bcd  <= bcd;
        dec_neg  <= pend_neg;
        dec_over <= pend_over;
      end
    end
  end

  always_comb begin
    dig_seg = {4{SEG_BLANK}};
    if (display_mode) begin
      for (int i = 0; i < 3; i++) dig_seg[i] = hex_to_seg(sel_val[i*4 +: 4]);
    end else if (dec_over) begin
      dig_seg = {4{SEG_MINUS}};
    end else begin
      if (dec_neg)                dig_seg[3] = SEG_MINUS;
      if (dec_bcd[11:8] != 4'd0)  dig_seg[2] = hex_to_seg(dec_bcd[11:8]);
      if (dec_bcd[11:4] != 8'd0)  dig_seg[1] = hex_to_seg(dec_bcd[7:4]);
      dig_seg[0] = hex_to_seg(dec_bcd[3:0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= dig_seg[idx];
    end
  end
endmodule
